// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the multi-cycle MDU: captures one EX operation at a time, times the MDU latency, and hands the result to writeback.
// wb handshake: wb_valid stays high with stable payload until the cycle wb_ready is also high; that cycle transfers.
module mdu_issue_ctrl #(
  parameter int ARCH_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int D_WIDTH     = 4,
  parameter int RADDR_WIDTH = 5,
  parameter int LAT         = 8,
  parameter int CNT_WIDTH   = 4,
  parameter logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(0),
  parameter logic [OP_WIDTH-1:0] OP_DIVW  = OP_WIDTH'(4),
  parameter logic [OP_WIDTH-1:0] OP_DIVWU = OP_WIDTH'(5)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [OP_WIDTH-1:0]    issue_op,
  input  logic [ARCH_WIDTH-1:0]  issue_a,
  input  logic [ARCH_WIDTH-1:0]  issue_b,
  input  logic [RADDR_WIDTH-1:0] issue_rd,
  input  logic                   issue_rc,
  input  logic                   flush,
  output logic                   stall,
  output logic                   mdu_req,
  output logic [OP_WIDTH-1:0]    mdu_op,
  output logic [ARCH_WIDTH-1:0]  mdu_a,
  output logic [ARCH_WIDTH-1:0]  mdu_b,
  input  logic [ARCH_WIDTH-1:0]  mdu_c,
  input  logic [D_WIDTH-1:0]     mdu_d,
  input  logic                   mdu_ack,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [RADDR_WIDTH-1:0] wb_rd,
  output logic [ARCH_WIDTH-1:0]  wb_data,
  output logic                   wb_cr_we,
  output logic [D_WIDTH-1:0]     wb_cr,
  output logic                   busy,
  output logic [RADDR_WIDTH-1:0] busy_rd,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t                 state, state_nx;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [OP_WIDTH-1:0]    op_q;
  logic [ARCH_WIDTH-1:0]  a_q, b_q, data_q;
  logic [RADDR_WIDTH-1:0] rd_q;
  logic                   rc_q;
  logic [D_WIDTH-1:0]     cr_q;
  logic                   accept, div_zero, complete;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    div_zero = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (issue_valid && issue_op != OP_NOP) begin
          accept   = 1'b1;
          div_zero = (issue_op == OP_DIVW || issue_op == OP_DIVWU) && issue_b == '0;
          state_nx = div_zero ? DONE : ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (cnt == '0 && mdu_ack) begin
          complete = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: if (wb_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Flush overrides acceptance, completion and handshake alike.
    if (flush) begin
      state_nx = IDLE;
      accept   = 1'b0;
      div_zero = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      rc_q   <= 1'b0;
      data_q <= '0;
      cr_q   <= '0;
    end else begin
      state <= state_nx;
      // Loaded at accept so the ISSUE cycle is the first of the LAT cycles.
      if (flush)
        cnt <= '0;
      else if (accept && !div_zero)
        cnt <= CNT_WIDTH'(LAT - 1);
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (accept) begin
        op_q <= issue_op;
        a_q  <= issue_a;
        b_q  <= issue_b;
        rd_q <= issue_rd;
        rc_q <= issue_rc;
      end
      if (div_zero) begin
        data_q <= '0;
        cr_q   <= {{(D_WIDTH-1){1'b0}}, 1'b1};
      end else if (complete) begin
        data_q <= mdu_c;
        cr_q   <= mdu_d;
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    stall     = issue_valid && busy && !flush;
    mdu_req   = (state == ISSUE);
    mdu_op    = busy ? op_q : '0;
    mdu_a     = busy ? a_q : '0;
    mdu_b     = busy ? b_q : '0;
    wb_valid  = (state == DONE);
    wb_cr_we  = (state == DONE) && rc_q;
    wb_rd     = rd_q;
    wb_data   = data_q;
    wb_cr     = cr_q;
    busy_rd   = busy ? rd_q : '0;
    state_dbg = state;
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl with a behavioural MDU and an expected-result queue.
module tb_mdu_issue_ctrl;
  localparam int LAT = 8;
  localparam logic [3:0] OP_NOP = 4'd0, OP_MULW = 4'd1, OP_MULH = 4'd2,
                         OP_MULHU = 4'd3, OP_DIVW = 4'd4, OP_DIVWU = 4'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_op = '0;
  logic [31:0] issue_a = '0, issue_b = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_rc = 1'b0;
  logic        flush = 1'b0;
  logic        stall, mdu_req;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic [31:0] mdu_c = '0;
  logic [3:0]  mdu_d = '0;
  logic        mdu_ack = 1'b1;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_cr_we;
  logic [3:0]  wb_cr;
  logic        busy;
  logic [4:0]  busy_rd;
  logic [1:0]  state_dbg;

  logic [41:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  mdu_issue_ctrl #(.ARCH_WIDTH(32), .OP_WIDTH(4), .D_WIDTH(4), .RADDR_WIDTH(5),
                   .LAT(LAT), .CNT_WIDTH(4), .OP_NOP(OP_NOP), .OP_DIVW(OP_DIVW),
                   .OP_DIVWU(OP_DIVWU)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .issue_rc(issue_rc),
    .flush(flush), .stall(stall), .mdu_req(mdu_req), .mdu_op(mdu_op),
    .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_c(mdu_c), .mdu_d(mdu_d), .mdu_ack(mdu_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_cr_we(wb_cr_we), .wb_cr(wb_cr), .busy(busy), .busy_rd(busy_rd),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_c(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    ref_c = '0;
    case (op)
      OP_MULW: ref_c = a * b;
      OP_MULH: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; ref_c = p[63:32]; end
      OP_MULHU: begin p = {32'b0, a} * {32'b0, b}; ref_c = p[63:32]; end
      OP_DIVW: ref_c = (b == 0) ? 32'd0 : 32'($signed(a) / $signed(b));
      OP_DIVWU: ref_c = (b == 0) ? 32'd0 : a / b;
      default: ref_c = '0;
    endcase
  endfunction

  function automatic logic [3:0] ref_d(input logic [31:0] c);
    ref_d = {1'b0, c[31], !c[31] && c != 0, c == 0};
  endfunction

  // behavioural MDU: result and flags stable from the cycle after mdu_req
  always @(posedge clk) begin
    if (mdu_req) begin
      mdu_c <= ref_c(mdu_op, mdu_a, mdu_b);
      mdu_d <= ref_d(ref_c(mdu_op, mdu_a, mdu_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present an op and push its expected writeback record
  task automatic drive_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic rc);
    logic [31:0] c;
    issue_valid = 1'b1;
    issue_op = op;
    issue_a = a;
    issue_b = b;
    issue_rd = rd;
    issue_rc = rc;
    c = ((op == OP_DIVW || op == OP_DIVWU) && b == 0) ? 32'd0 : ref_c(op, a, b);
    exp_q.push_back({rd, c, ((op == OP_DIVW || op == OP_DIVWU) && b == 0) ? 4'b0001 : ref_d(c), rc});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    checks++;
    if ({stall, mdu_req, mdu_op, mdu_a, mdu_b, wb_valid, wb_rd, wb_data, wb_cr_we, wb_cr, busy, busy_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b op=%h a=%h b=%h wbv=%b rd=%h data=%h we=%b cr=%h busy=%b brd=%h, want all 0",
               mdu_req, mdu_op, mdu_a, mdu_b, wb_valid, wb_rd, wb_data, wb_cr_we, wb_cr, busy, busy_rd);
    end
  endtask

  task automatic test_mulw();
    int k;
    int extra_req;
    logic [41:0] e;
    wb_ready = 1'b1;
    drive_issue(OP_MULW, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
    tick();
    issue_valid = 1'b0;
    k = 1;
    checks++;
    if (!(mdu_req === 1'b1 && mdu_op === OP_MULW && mdu_a === 32'd7 && mdu_b === 32'hFFFFFFFD)) begin
      errors++;
      $display("FAIL mulw_req: req=%b op=%h a=%h b=%h want 1 %h 7 fffffffd", mdu_req, mdu_op, mdu_a, mdu_b, OP_MULW);
    end
    checks++;
    if (busy !== 1'b1 || busy_rd !== 5'd5) begin
      errors++;
      $display("FAIL mulw_busy: busy=%b busy_rd=%0d want 1 5", busy, busy_rd);
    end
    extra_req = 0;
    tick();
    k = 2;
    while (!wb_valid && k < 40) begin
      if (mdu_req !== 1'b0 || mdu_a !== 32'd7) extra_req++;
      tick();
      k++;
    end
    checks++;
    if (extra_req != 0) begin
      errors++;
      $display("FAIL mulw_req_pulse: %0d bad cycles after ISSUE, want 0", extra_req);
    end
    checks++;
    if (k != LAT + 1 || !wb_valid) begin
      errors++;
      $display("FAIL mulw_latency: wb_valid=%b at T+%0d want T+%0d", wb_valid, k, LAT + 1);
    end
    checks++;
    if (wb_data !== 32'hFFFFFFEB || wb_cr[2] !== 1'b1 || wb_rd !== 5'd5 || wb_cr_we !== 1'b1) begin
      errors++;
      $display("FAIL mulw_result: data=%h cr=%b rd=%0d we=%b want ffffffeb LT=1 5 1", wb_data, wb_cr, wb_rd, wb_cr_we);
    end
    e = exp_q.pop_front();
    checks++;
    if ({wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL mulw_scoreboard: got %h want %h", {wb_rd, wb_data, wb_cr, wb_cr_we}, e);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 || mdu_a !== 32'd0 || busy_rd !== 5'd0) begin
      errors++;
      $display("FAIL mulw_idle: busy=%b wbv=%b mdu_a=%h busy_rd=%0d want 0 0 0 0", busy, wb_valid, mdu_a, busy_rd);
    end
  endtask

  task automatic test_divwu_backpressure();
    int k;
    logic [41:0] e;
    wb_ready = 1'b0;
    drive_issue(OP_DIVWU, 32'hFFFFFFFE, 32'd2, 5'd12, 1'b0);
    tick();
    issue_valid = 1'b0;
    k = 1;
    while (!wb_valid && k < 40) begin tick(); k++; end
    checks++;
    if (k != LAT + 1 || !wb_valid) begin
      errors++;
      $display("FAIL divwu_latency: wb_valid=%b at T+%0d want T+%0d", wb_valid, k, LAT + 1);
    end
    e = exp_q.pop_front();
    checks++;
    if ({wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL divwu_scoreboard: got %h want %h", {wb_rd, wb_data, wb_cr, wb_cr_we}, e);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h7FFFFFFF || wb_rd !== 5'd12 || wb_cr_we !== 1'b0) begin
        errors++;
        $display("FAIL divwu_hold%0d: wbv=%b data=%h rd=%0d we=%b want 1 7fffffff 12 0", i, wb_valid, wb_data, wb_rd, wb_cr_we);
      end
    end
    wb_ready = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 2'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL divwu_release: state=%0d wbv=%b want 0 0", state_dbg, wb_valid);
    end
  endtask

  task automatic test_div_zero();
    logic [41:0] e;
    wb_ready = 1'b1;
    drive_issue(OP_DIVW, 32'd5, 32'd0, 5'd3, 1'b1);
    tick();
    issue_valid = 1'b0;
    checks++;
    if (mdu_req !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd0 || wb_cr !== 4'b0001 || wb_cr_we !== 1'b1) begin
      errors++;
      $display("FAIL divzero_result: req=%b wbv=%b data=%h cr=%b we=%b want 0 1 0 0001 1",
               mdu_req, wb_valid, wb_data, wb_cr, wb_cr_we);
    end
    e = exp_q.pop_front();
    checks++;
    if ({wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL divzero_scoreboard: got %h want %h", {wb_rd, wb_data, wb_cr, wb_cr_we}, e);
    end
    tick();
    checks++;
    if (state_dbg !== 2'd0 || mdu_req !== 1'b0) begin
      errors++;
      $display("FAIL divzero_idle: state=%0d req=%b want 0 0", state_dbg, mdu_req);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int bad;
    logic [41:0] e;
    wb_ready = 1'b1;
    drive_issue(OP_MULW, 32'd100, 32'd200, 5'd3, 1'b0);
    tick();
    drive_issue(OP_DIVWU, 32'd1000, 32'd7, 5'd9, 1'b1);
    k = 1;
    bad = 0;
    while (!wb_valid && k < 40) begin
      if (stall !== 1'b1 || busy_rd !== 5'd3) bad++;
      tick();
      k++;
    end
    checks++;
    if (bad != 0 || stall !== 1'b1 || busy_rd !== 5'd3 || !wb_valid) begin
      errors++;
      $display("FAIL b2b_stall: %0d bad cycles, stall=%b busy_rd=%0d wbv=%b want stall 1 rd 3", bad, stall, busy_rd, wb_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if ({wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h", {wb_rd, wb_data, wb_cr, wb_cr_we}, e);
    end
    tick();
    checks++;
    if (state_dbg !== 2'd0 || stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: state=%0d stall=%b busy=%b want 0 0 0", state_dbg, stall, busy);
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if (mdu_req !== 1'b1 || busy_rd !== 5'd9) begin
      errors++;
      $display("FAIL b2b_second_issue: req=%b busy_rd=%0d want 1 9", mdu_req, busy_rd);
    end
    k = 1;
    while (!wb_valid && k < 40) begin tick(); k++; end
    checks++;
    e = exp_q.pop_front();
    if (k != LAT + 1 || {wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL b2b_second: at T+%0d got %h want T+%0d %h", k, {wb_rd, wb_data, wb_cr, wb_cr_we}, LAT + 1, e);
    end
    tick();
  endtask

  task automatic test_flush();
    int k;
    int early;
    logic [41:0] e;
    wb_ready = 1'b1;
    drive_issue(OP_MULW, 32'd11, 32'd13, 5'd7, 1'b1);
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    void'(exp_q.pop_front());
    flush = 1'b1;
    drive_issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b want 0", stall);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: state=%0d busy=%b wbv=%b stall=%b want 0 0 0 0", state_dbg, busy, wb_valid, stall);
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if (mdu_req !== 1'b1 || busy_rd !== 5'd8) begin
      errors++;
      $display("FAIL flush_reissue: req=%b busy_rd=%0d want 1 8", mdu_req, busy_rd);
    end
    k = 1;
    early = 0;
    while (!wb_valid && k < 40) begin tick(); k++; end
    e = exp_q.pop_front();
    checks++;
    if (k != LAT + 1 || {wb_rd, wb_data, wb_cr, wb_cr_we} !== e || wb_data !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL flush_new_op: at T+%0d got %h want T+%0d %h", k, {wb_rd, wb_data, wb_cr, wb_cr_we}, LAT + 1, e);
    end
    tick();
  endtask

  task automatic test_ack_hold();
    int k;
    int early;
    logic [41:0] e;
    wb_ready = 1'b1;
    mdu_ack = 1'b0;
    drive_issue(OP_DIVWU, 32'd1000, 32'd10, 5'd4, 1'b1);
    tick();
    issue_valid = 1'b0;
    k = 1;
    early = 0;
    while (k < LAT + 3) begin
      if (wb_valid !== 1'b0) early++;
      tick();
      k++;
    end
    checks++;
    if (early != 0 || state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL ack_wait: %0d early wb_valid cycles, state=%0d want 0 and WAIT(2)", early, state_dbg);
    end
    mdu_ack = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || {wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL ack_result: wbv=%b got %h want 1 %h", wb_valid, {wb_rd, wb_data, wb_cr, wb_cr_we}, e);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int k;
    logic [41:0] e;
    wb_ready = 1'b1;
    drive_issue(OP_MULW, 32'd5, 32'd6, 5'd10, 1'b1);
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    void'(exp_q.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({stall, mdu_req, mdu_op, mdu_a, mdu_b, wb_valid, wb_rd, wb_data, wb_cr_we, wb_cr, busy, busy_rd, state_dbg} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: req=%b a=%h wbv=%b rd=%h data=%h cr=%h busy=%b brd=%h state=%0d want all 0",
               mdu_req, mdu_a, wb_valid, wb_rd, wb_data, wb_cr, busy, busy_rd, state_dbg);
    end
    drive_issue(OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd11, 1'b1);
    tick();
    issue_valid = 1'b0;
    k = 1;
    while (!wb_valid && k < 40) begin tick(); k++; end
    e = exp_q.pop_front();
    checks++;
    if (k != LAT + 1 || {wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
      errors++;
      $display("FAIL rst_mid_mulh: at T+%0d got %h want T+%0d %h", k, {wb_rd, wb_data, wb_cr, wb_cr_we}, LAT + 1, e);
    end
    tick();
  endtask

  task automatic test_random();
    int k;
    int hold;
    logic [3:0] op;
    logic [41:0] e;
    for (int n = 0; n < 10; n++) begin
      op = 4'($urandom_range(1, 5));
      wb_ready = 1'b0;
      drive_issue(op, $urandom, (n % 4 == 0) ? 32'd0 : $urandom, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
      issue_valid = (op == OP_DIVW && issue_b == 32'd0) ? 1'b1 : 1'b1;
      if (op == OP_DIVW) begin
        issue_b = 32'($urandom_range(1, 1000));
        void'(exp_q.pop_back());
        drive_issue(op, issue_a, issue_b, issue_rd, issue_rc);
      end
      tick();
      issue_valid = 1'b0;
      k = 1;
      while (!wb_valid && k < 40) begin tick(); k++; end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) tick();
      e = exp_q.pop_front();
      checks++;
      if (wb_valid !== 1'b1 || {wb_rd, wb_data, wb_cr, wb_cr_we} !== e) begin
        errors++;
        $display("FAIL random_%0d op=%0d: wbv=%b got %h want %h", n, op, wb_valid, {wb_rd, wb_data, wb_cr, wb_cr_we}, e);
      end
      wb_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mulw();
    test_divwu_backpressure();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_ack_hold();
    test_rst_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
